full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1, operand/sum width in bits; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock for the output register stage.
REQ-003 reset  input  1  asynchronous, active-high reset of all registered state.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B.
REQ-006 ci  input  1  carry-in to bit 0.
REQ-007 in_valid  input  1  qualifies a, b, ci for capture into the output register.
REQ-008 out  output  WIDTH  combinational sum.
REQ-009 co  output  1  combinational carry-out of bit WIDTH-1.
REQ-010 ovf  output  1  combinational signed overflow; present only per REQ-025.
REQ-011 out_q  output  WIDTH  registered sum.
REQ-012 co_q  output  1  registered carry-out.
REQ-013 ovf_q  output  1  registered overflow; present only per REQ-025.
REQ-014 vld_q  output  1  registered valid, high when out_q/co_q hold a fresh result.

Function
REQ-015 Ripple-carry chain of WIDTH one-bit cells; cell i: out[i] = a[i] ^ b[i] ^ c[i], c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = ci.
REQ-016 co = c[WIDTH]; {co, out} equals a + b + ci, zero-extended to WIDTH+1 bits, for all inputs.
REQ-017 out and co are purely combinational: no latency, independent of clk, reset and in_valid.
REQ-018 Wrap-around: all-ones + 0 with ci=1 gives out = 0, co = 1; all-ones + all-ones with ci=1 gives out = all-ones, co = 1.
REQ-019 On a rising clk edge with in_valid=1: out_q <= out, co_q <= co, ovf_q <= ovf, vld_q <= 1 (latency exactly one cycle).
REQ-020 On a rising clk edge with in_valid=0: out_q, co_q, ovf_q hold their values; vld_q <= 0.
REQ-021 No back-pressure; every valid input cycle is accepted and overwrites the previous registered result.

Reset
REQ-022 While reset=1, out_q, co_q, ovf_q and vld_q are 0 immediately, independent of clk.
REQ-023 Reset asserted mid-operation discards the pending registered result; the first capture after release occurs at the first rising clk edge with reset=0 and in_valid=1.
REQ-024 Reset has no effect on the combinational outputs out and co.

Configuration
REQ-025 Macro FULL_ADDER_OVF_EN defined: ovf = c[WIDTH] ^ c[WIDTH-1] (two's-complement overflow), ovf_q is registered per REQ-019/020/022; macro undefined: ovf and ovf_q ports are still present but tied to constant 0, and no overflow logic or register is built.

Verification
REQ-026 WIDTH=1, exhaustive over all 8 combinations of a, b, ci -> {co,out} equals a+b+ci (e.g. 1,1,1 -> co=1, out=1; 1,0,0 -> co=0, out=1).
REQ-027 WIDTH=64, a=1, b=4, ci=0 -> out=5, co=0 combinationally; with in_valid=1 -> out_q=5, vld_q=1 one cycle later.
REQ-028 WIDTH=64, a=all-ones, b=0, ci=1 -> out=0, co=1; with FULL_ADDER_OVF_EN defined, ovf=0; a=0x7FFF_FFFF_FFFF_FFFF, b=1, ci=0 -> ovf=1; with the macro undefined -> ovf=0.
REQ-029 in_valid toggles 1,0,1 with distinct operands -> out_q updates only on valid cycles; vld_q follows in_valid delayed by one cycle.
REQ-030 Assert reset between clock edges while vld_q=1 -> out_q, co_q, ovf_q and vld_q become 0 before the next edge; out and co are unchanged.

Source files
------------

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder: combinational sum/carry plus a one-stage registered copy.
// Define FULL_ADDER_OVF_EN to build the signed-overflow flag; otherwise ovf/ovf_q read as 0.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             ovf,
  output logic [WIDTH-1:0] out_q,
  output logic             co_q,
  output logic             ovf_q,
  output logic             vld_q
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_out_q;
  logic             r_co_q;
  logic             r_vld_q;

  assign w_c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_p;
    assign w_p        = a[i] ^ b[i];
    assign w_sum[i]   = w_p ^ w_c[i];
    assign w_c[i+1]   = (a[i] & b[i]) | (w_c[i] & w_p);
  end

  assign out = w_sum;
  assign co  = w_c[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_q <= '0;
      r_co_q  <= 1'b0;
      r_vld_q <= 1'b0;
    end else begin
      r_vld_q <= in_valid;
      if (in_valid) begin
        r_out_q <= w_sum;
        r_co_q  <= w_c[WIDTH];
      end
    end
  end

  assign out_q = r_out_q;
  assign co_q  = r_co_q;
  assign vld_q = r_vld_q;

`ifdef FULL_ADDER_OVF_EN
  logic w_ovf;
  logic r_ovf_q;

  // Carries into and out of the sign bit disagree exactly on two's-complement overflow.
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_q <= 1'b0;
    end else if (in_valid) begin
      r_ovf_q <= w_ovf;
    end
  end

  assign ovf   = w_ovf;
  assign ovf_q = r_ovf_q;
`else
  assign ovf   = 1'b0;
  assign ovf_q = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 and WIDTH=64 instances against an arithmetic model.
// Honours FULL_ADDER_OVF_EN for the expected overflow values.
module tb_full_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ci;
  logic        in_valid;
  logic        a1, b1;
  logic [63:0] a64, b64;

  logic        out1, co1, ovf1, out_q1, co_q1, ovf_q1, vld_q1;
  logic [63:0] out64, out_q64;
  logic        co64, ovf64, co_q64, ovf_q64, vld_q64;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] e_q64;
  logic        e_co64, e_ovf64, e_q1, e_co1, e_ovf1, e_vld;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .ci(ci), .in_valid(in_valid),
    .out(out1), .co(co1), .ovf(ovf1), .out_q(out_q1), .co_q(co_q1), .ovf_q(ovf_q1),
    .vld_q(vld_q1)
  );

  full_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .reset(reset), .a(a64), .b(b64), .ci(ci), .in_valid(in_valid),
    .out(out64), .co(co64), .ovf(ovf64), .out_q(out_q64), .co_q(co_q64), .ovf_q(ovf_q64),
    .vld_q(vld_q64)
  );

  typedef struct {
    logic a, b, ci;
    logic e_co, e_out;
  } vec1_t;

  typedef struct {
    logic [63:0] a, b;
    logic        ci;
    logic [63:0] e_out;
    logic        e_co, e_ovf;
  } vec64_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {ovf, co, out}; arithmetic on wide signed/unsigned values, masked to w bits.
  function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input int w);
    logic [63:0]        mask, am, bm, o;
    logic [64:0]        s;
    logic signed [66:0] sa, sb, ss, lo, hi;
    logic               c, v;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = b & mask;
    s    = {1'b0, am} + {1'b0, bm} + 65'(ci);
    o    = s[63:0] & mask;
    c    = s[w];
    sa   = $signed({3'b000, am});
    sb   = $signed({3'b000, bm});
    if (am[w-1]) sa = sa - (67'sd1 <<< w);
    if (bm[w-1]) sb = sb - (67'sd1 <<< w);
    ss   = sa + sb + $signed({66'd0, ci});
    lo   = -(67'sd1 <<< (w - 1));
    hi   = (67'sd1 <<< (w - 1)) - 67'sd1;
`ifdef FULL_ADDER_OVF_EN
    v    = (ss < lo) || (ss > hi);
`else
    v    = 1'b0;
`endif
    return {v, c, o};
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, " out_q1"}, 64'(out_q1), 64'(e_q1));
    chk({tag, " co_q1"}, 64'(co_q1), 64'(e_co1));
    chk({tag, " ovf_q1"}, 64'(ovf_q1), 64'(e_ovf1));
    chk({tag, " vld_q1"}, 64'(vld_q1), 64'(e_vld));
    chk({tag, " out_q64"}, out_q64, e_q64);
    chk({tag, " co_q64"}, 64'(co_q64), 64'(e_co64));
    chk({tag, " ovf_q64"}, 64'(ovf_q64), 64'(e_ovf64));
    chk({tag, " vld_q64"}, 64'(vld_q64), 64'(e_vld));
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic run(input string tag, input logic ia1, input logic ib1, input logic [63:0] ia64,
                     input logic [63:0] ib64, input logic ici, input logic iv,
                     input logic x1_out, input logic x1_co, input logic x1_ovf,
                     input logic [63:0] x64_out, input logic x64_co, input logic x64_ovf);
    a1 = ia1; b1 = ib1; a64 = ia64; b64 = ib64; ci = ici; in_valid = iv;
    #1;
    chk({tag, " out1"}, 64'(out1), 64'(x1_out));
    chk({tag, " co1"}, 64'(co1), 64'(x1_co));
    chk({tag, " ovf1"}, 64'(ovf1), 64'(x1_ovf));
    chk({tag, " out64"}, out64, x64_out);
    chk({tag, " co64"}, 64'(co64), 64'(x64_co));
    chk({tag, " ovf64"}, 64'(ovf64), 64'(x64_ovf));
    e_vld = iv;
    if (iv) begin
      e_q1 = x1_out; e_co1 = x1_co; e_ovf1 = x1_ovf;
      e_q64 = x64_out; e_co64 = x64_co; e_ovf64 = x64_ovf;
    end
    @(posedge clk);
    #1;
    chk_regs(tag);
  endtask

  task automatic run_model(input string tag, input logic ia1, input logic ib1,
                           input logic [63:0] ia64, input logic [63:0] ib64,
                           input logic ici, input logic iv);
    logic [65:0] r1, r64;
    r1  = ref_add(64'(ia1), 64'(ib1), ici, 1);
    r64 = ref_add(ia64, ib64, ici, 64);
    run(tag, ia1, ib1, ia64, ib64, ici, iv, r1[0], r1[64], r1[65], r64[63:0], r64[64], r64[65]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    vec1_t  t1[8];
    vec64_t t64[5];
    logic   ovf_en;
`ifdef FULL_ADDER_OVF_EN
    ovf_en = 1'b1;
`else
    ovf_en = 1'b0;
`endif

    t1[0] = '{0, 0, 0, 0, 0};  t1[1] = '{0, 0, 1, 0, 1};
    t1[2] = '{0, 1, 0, 0, 1};  t1[3] = '{0, 1, 1, 1, 0};
    t1[4] = '{1, 0, 0, 0, 1};  t1[5] = '{1, 0, 1, 1, 0};
    t1[6] = '{1, 1, 0, 1, 0};  t1[7] = '{1, 1, 1, 1, 1};

    t64[0] = '{64'd1, 64'd4, 1'b0, 64'd5, 1'b0, 1'b0};
    t64[1] = '{'1, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
    t64[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    t64[3] = '{'1, '1, 1'b1, '1, 1'b1, 1'b0};
    t64[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};

    reset = 1'b1; ci = 1'b0; in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a64 = '0; b64 = '0;
    e_q1 = 0; e_co1 = 0; e_ovf1 = 0; e_q64 = '0; e_co64 = 0; e_ovf64 = 0; e_vld = 0;
    #12;
    chk_regs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // WIDTH=1 exhaustive against hand-written sums; 64-bit side adds 0+0+ci.
    for (int i = 0; i < 8; i++) begin
      run($sformatf("w1[%0d]", i), t1[i].a, t1[i].b, 64'd0, 64'd0, t1[i].ci, 1'b1,
          t1[i].e_out, t1[i].e_co, ovf_en & (t1[i].e_co ^ t1[i].ci),
          64'(t1[i].ci), 1'b0, 1'b0);
    end

    for (int i = 0; i < 5; i++) begin
      run($sformatf("w64[%0d]", i), 1'b0, 1'b0, t64[i].a, t64[i].b, t64[i].ci, 1'b1,
          t64[i].ci, 1'b0, 1'b0, t64[i].e_out, t64[i].e_co, ovf_en & t64[i].e_ovf);
    end

    // Valid toggling: registered result holds across the idle cycle.
    run_model("tog0", 1'b1, 1'b0, 64'h1111, 64'h2222, 1'b0, 1'b1);
    run_model("tog1", 1'b0, 1'b1, 64'hAAAA, 64'h5555, 1'b1, 1'b0);
    run_model("tog2", 1'b1, 1'b1, 64'hFFFF_0000, 64'h0001_0000, 1'b1, 1'b1);

    // Reset between edges while a fresh result is held.
    run_model("pre_rst", 1'b1, 1'b1, '1, 64'd2, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    e_q1 = 0; e_co1 = 0; e_ovf1 = 0; e_q64 = '0; e_co64 = 0; e_ovf64 = 0; e_vld = 0;
    chk_regs("mid_rst");
    chk("mid_rst out64", out64, 64'd2);
    chk("mid_rst co64", 64'(co64), 64'd1);
    chk("mid_rst out1", 64'(out1), 64'd1);
    @(posedge clk);
    #1;
    chk_regs("held_rst");
    reset = 1'b0;
    run_model("post_rst", 1'b0, 1'b1, 64'd100, 64'd23, 1'b0, 1'b1);

    // Randomised traffic with occasional corner operands.
    for (int i = 0; i < 300; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = 64'h7FFF_FFFF_FFFF_FFFF;
        2: rb = ~ra;
        default: ;
      endcase
      run_model($sformatf("rnd[%0d]", i), 1'($urandom), 1'($urandom), ra, rb,
                1'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
